// File: rtl/ma_pkg.sv
// Shared types and helpers for the moving-average channel scheduler.
package ma_pkg;

  localparam int DATA_WD = 16;

  typedef logic signed [DATA_WD-1:0] hist_t [3];
  typedef logic signed [DATA_WD+1:0] sum_t;

  function automatic int ch_wd(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1 .. ptr+N (mod N) for the first request.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  always_comb begin
    int  j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    if (en) begin
      for (int i = 1; i <= N; i++) begin
        j = (int'(ptr) + i) % N;
        if (!found && req[j]) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ma_channel_scheduler.sv
// Shares one 4-tap moving-average datapath among N_CH sources with round-robin arbitration.
// Optional MA_FLUSH_EN adds the per-channel i_flush history clear.
module ma_channel_scheduler
  import ma_pkg::*;
#(
  parameter int DATA_WD = ma_pkg::DATA_WD,
  parameter int N_CH    = 4,
  localparam int CH_WD  = ch_wd(N_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rstb,
  input  logic [N_CH-1:0]         i_req_valid,
  output logic [N_CH-1:0]         o_req_ready,
  input  logic [N_CH*DATA_WD-1:0] i_req_data,
  output logic                    o_valid,
  output logic [CH_WD-1:0]        o_ch,
  output logic [DATA_WD-1:0]      o_data,
  input  logic                    i_out_ready
`ifdef MA_FLUSH_EN
  ,
  input  logic [N_CH-1:0]         i_flush
`endif
);

  logic signed [DATA_WD-1:0] h0 [N_CH];
  logic signed [DATA_WD-1:0] h1 [N_CH];
  logic signed [DATA_WD-1:0] h2 [N_CH];

  logic [CH_WD-1:0]   ptr;
  logic               slot_free;
  logic [N_CH-1:0]    gnt;
  logic [CH_WD-1:0]   gnt_idx;
  logic               accept;
  logic [N_CH-1:0]    flush_v;
  logic               flush_k;

  logic signed [DATA_WD-1:0] d;
  logic signed [DATA_WD-1:0] t0, t1, t2;
  logic signed [DATA_WD+1:0] sum;
  logic [DATA_WD-1:0]        avg;

`ifdef MA_FLUSH_EN
  assign flush_v = i_flush;
`else
  assign flush_v = '0;
`endif

  assign slot_free   = ~o_valid | i_out_ready;
  assign accept      = |gnt;
  assign o_req_ready = gnt;

  rr_arbiter #(
    .N (N_CH),
    .W (CH_WD)
  ) u_arb (
    .req     (i_req_valid),
    .ptr     (ptr),
    .en      (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A same-cycle flush takes effect before the sum, so the taps read as zero.
  always_comb begin
    d       = i_req_data[int'(gnt_idx)*DATA_WD +: DATA_WD];
    flush_k = flush_v[gnt_idx];
    t0      = flush_k ? '0 : h0[gnt_idx];
    t1      = flush_k ? '0 : h1[gnt_idx];
    t2      = flush_k ? '0 : h2[gnt_idx];
    sum     = {{2{d[DATA_WD-1]}},  d}
            + {{2{t0[DATA_WD-1]}}, t0}
            + {{2{t1[DATA_WD-1]}}, t1}
            + {{2{t2[DATA_WD-1]}}, t2};
  end

  assign avg = DATA_WD'(sum >>> 2);

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      for (int k = 0; k < N_CH; k++) begin
        h0[k] <= '0;
        h1[k] <= '0;
        h2[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (flush_v[k]) begin
          h0[k] <= gnt[k] ? d : '0;
          h1[k] <= '0;
          h2[k] <= '0;
        end else if (gnt[k]) begin
          h0[k] <= d;
          h1[k] <= h0[k];
          h2[k] <= h1[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_data  <= '0;
      ptr     <= CH_WD'(N_CH - 1);
    end else if (accept) begin
      o_valid <= 1'b1;
      o_ch    <= gnt_idx;
      o_data  <= avg;
      ptr     <= gnt_idx;
    end else if (i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
